// File: rtl/line_dma_pkg.sv
// Shared types and constants for the line DMA writer (state encoding, status layout).
package line_dma_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        WAIT_DATA,
        BURST
    } state_t;

    localparam int WORD_BYTES = 16;

    localparam int ST_BUSY    = 31;
    localparam int ST_OVF     = 30;
    localparam int ST_CFGERR  = 29;
    localparam int ST_LINES_W = 24;

endpackage

// File: rtl/line_dma_ring_ptr.sv
// Ring write-offset tracker: burst length selection and wrap detection.
// Wrap pulse is built only when LINE_DMA_WRITER_WRAP_IRQ_EN is defined.
module line_dma_ring_ptr #(
    parameter int BURST_LEN = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        advance,
    input  logic [27:0] size_w,
    output logic [27:0] wr_off,
    output logic [7:0]  blen,
    output logic        wrap
);

    logic [27:0] remain;
    logic [27:0] next_off;
    logic        at_end;

    always_comb begin
        remain   = size_w - wr_off;
        blen     = (remain < 28'(BURST_LEN)) ? remain[7:0] : 8'(BURST_LEN);
        next_off = wr_off + 28'(blen);
        at_end   = (next_off == size_w);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_off <= '0;
        end else if (clear) begin
            wr_off <= '0;
        end else if (advance) begin
            wr_off <= at_end ? '0 : next_off;
        end
    end

`ifdef LINE_DMA_WRITER_WRAP_IRQ_EN
    logic wrap_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= advance && at_end && !clear;
        end
    end

    assign wrap = wrap_q;
`else
    assign wrap = 1'b0;
`endif

endmodule

// File: rtl/line_dma_writer.sv
// Avalon-MM burst-write DMA draining the line FIFO into an SDRAM ring buffer.
// Optional wrap interrupt: define LINE_DMA_WRITER_WRAP_IRQ_EN.
module line_dma_writer
    import line_dma_pkg::*;
#(
    parameter int BURST_LEN  = 16,
    parameter int LINE_WORDS = 256,
    parameter int USEDW_W    = 9
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [31:0]        buf_base,
    input  logic [31:0]        buf_size,
    input  logic [127:0]       fifo_rdata,
    input  logic [USEDW_W-1:0] fifo_usedw,
    input  logic               fifo_full,
    output logic               fifo_rdreq,
    output logic [27:0]        sdram0_address,
    output logic [7:0]         sdram0_burstcount,
    output logic [127:0]       sdram0_writedata,
    output logic [15:0]        sdram0_byteenable,
    output logic               sdram0_write,
    input  logic               sdram0_waitrequest,
    output logic [31:0]        dma_status,
    output logic               line_irq,
    output logic               wrap_irq
);

    localparam int WORD_SHIFT = $clog2(WORD_BYTES);
    localparam int WCNT_W     = $clog2(LINE_WORDS + 1);

    state_t              state;
    logic                en_q;
    logic [27:0]         base_w;
    logic [27:0]         size_w;
    logic [7:0]          beat_cnt;
    logic [WCNT_W-1:0]   word_cnt;
    logic [23:0]         lines;
    logic                ovf;
    logic                cfg_err;
    logic                beat_ok;
    logic                last_beat;
    logic [27:0]         wr_off;
    logic [7:0]          blen;
    logic                unused_low_bits;

    assign unused_low_bits = ^{buf_base[WORD_SHIFT-1:0], buf_size[WORD_SHIFT-1:0]};

    assign beat_ok           = sdram0_write && !sdram0_waitrequest;
    assign last_beat         = (beat_cnt == sdram0_burstcount - 8'd1);
    assign fifo_rdreq        = beat_ok;
    assign sdram0_writedata  = fifo_rdata;
    assign sdram0_byteenable = '1;

    line_dma_ring_ptr #(
        .BURST_LEN (BURST_LEN)
    ) u_ring_ptr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state == ARM),
        .advance (state == BURST && beat_ok && last_beat),
        .size_w  (size_w),
        .wr_off  (wr_off),
        .blen    (blen),
        .wrap    (wrap_irq)
    );

    always_comb begin
        dma_status                   = '0;
        dma_status[ST_BUSY]          = (state != IDLE);
        dma_status[ST_OVF]           = ovf;
        dma_status[ST_CFGERR]        = cfg_err;
        dma_status[ST_LINES_W-1:0]   = lines;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            en_q              <= 1'b0;
            base_w            <= '0;
            size_w            <= '0;
            sdram0_address    <= '0;
            sdram0_burstcount <= '0;
            sdram0_write      <= 1'b0;
            beat_cnt          <= '0;
            word_cnt          <= '0;
            lines             <= '0;
            ovf               <= 1'b0;
            cfg_err           <= 1'b0;
            line_irq          <= 1'b0;
        end else begin
            en_q     <= enable;
            line_irq <= 1'b0;

            if (state != IDLE && fifo_full) begin
                ovf <= 1'b1;
            end

            // Line accounting runs on every accepted beat, independent of burst framing.
            if (beat_ok) begin
                if (word_cnt == WCNT_W'(LINE_WORDS - 1)) begin
                    word_cnt <= '0;
                    line_irq <= 1'b1;
                    lines    <= lines + 24'd1;
                end else begin
                    word_cnt <= word_cnt + 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (enable && !en_q) begin
                        state <= ARM;
                    end
                end
                ARM: begin
                    base_w   <= buf_base[31:WORD_SHIFT];
                    size_w   <= buf_size[31:WORD_SHIFT];
                    word_cnt <= '0;
                    lines    <= '0;
                    ovf      <= 1'b0;
                    if (buf_size[31:WORD_SHIFT] == '0) begin
                        cfg_err <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        cfg_err <= 1'b0;
                        state   <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (32'(fifo_usedw) >= 32'(blen)) begin
                        sdram0_address    <= base_w + wr_off;
                        sdram0_burstcount <= blen;
                        beat_cnt          <= '0;
                        sdram0_write      <= 1'b1;
                        state             <= BURST;
                    end
                end
                BURST: begin
                    // A started burst always runs to its last beat; enable is only honoured after it.
                    if (beat_ok) begin
                        if (last_beat) begin
                            sdram0_write <= 1'b0;
                            state        <= enable ? WAIT_DATA : IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + 8'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
